// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse checker: FSM state type, default
// run-light timing constants and the error counter width.
// Imported by led_pulse_checker and led_edge_detect.
package led_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  // Default run-light timing in clocks.
  localparam int LED_PERIOD = 21;
  localparam int LED_HIGH   = 5;

  // Width of the saturating error counter.
  localparam int ERR_W = 8;

endpackage

// File: rtl/led_edge_detect.sv
// Rising-edge detector for the LED line under test, with an optional
// 2-flop synchronizer in front (enabled by defining LED_CHK_SYNC_EN).
// Ports: clk_i/rst_i (sync active-high), led_i raw line,
//        level_o (line level used for measurement), rise_o (0->1 strobe).
module led_edge_detect
  import led_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic led_i,
  output logic level_o,
  output logic rise_o
);

  logic prev_q;

`ifdef LED_CHK_SYNC_EN
  // Line may be asynchronous to clk_i: two flops before any use.
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= led_i;
      sync2_q <= sync1_q;
    end
  end

  assign level_o = sync2_q;
`else
  // Line is already synchronous to clk_i; use it directly.
  assign level_o = led_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_o;
    end
  end

  assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/led_pulse_checker.sv
// Measures high time and period of an LED pulse train, checks them against
// EXP_HIGH/EXP_PERIOD +/- TOL, and reports lock status and error counts.
// Ports: CLK, RST (sync active-high), Enable, LED_In in; High_Cnt,
//        Period_Cnt, Meas_Valid, Locked, Err_Pulse, Err_Cnt out.
// Optional macro LED_CHK_SYNC_EN adds a 2-flop input synchronizer.
module led_pulse_checker
  import led_pkg::*;
#(
  parameter int CNT_W      = 23,
  parameter int EXP_PERIOD = LED_PERIOD,
  parameter int EXP_HIGH   = LED_HIGH,
  parameter int TOL        = 0,
  parameter int LOCK_N     = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             LED_In,
  output logic [CNT_W-1:0] High_Cnt,
  output logic [CNT_W-1:0] Period_Cnt,
  output logic             Meas_Valid,
  output logic             Locked,
  output logic             Err_Pulse,
  output logic [ERR_W-1:0] Err_Cnt
);

  localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [GW-1:0]    LOCK_V  = GW'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(2 * EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_P_S = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   EXP_H_S = (CNT_W + 1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   TOL_S   = (CNT_W + 1)'(TOL);

  logic level;
  logic rise;

  led_edge_detect u_edge (
    .clk_i   (CLK),
    .rst_i   (RST),
    .led_i   (LED_In),
    .level_o (level),
    .rise_o  (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             mv_q, mv_d;
  logic             ep_q, ep_d;
  logic             lock_q, lock_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [GW-1:0]    good_q, good_d;

  // Deviation of the running counters from nominal, one extra bit so the
  // unsigned counters can be compared as signed values.
  logic signed [CNT_W:0] per_dev, hi_dev, per_abs, hi_abs;
  logic                  good;

  assign per_dev = $signed({1'b0, per_q}) - $signed(EXP_P_S);
  assign hi_dev  = $signed({1'b0, hi_q}) - $signed(EXP_H_S);
  assign per_abs = per_dev[CNT_W] ? -per_dev : per_dev;
  assign hi_abs  = hi_dev[CNT_W] ? -hi_dev : hi_dev;
  assign good    = (per_abs <= $signed(TOL_S)) && (hi_abs <= $signed(TOL_S));

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    high_d   = high_q;
    period_d = period_q;
    mv_d     = 1'b0;
    ep_d     = 1'b0;
    lock_d   = lock_q;
    err_d    = err_q;
    good_d   = good_q;

    unique case (state_q)
      IDLE: begin
        if (Enable && rise) begin
          state_d = MEAS;
          per_d   = CNT_ONE;
          hi_d    = CNT_ONE;
        end
      end
      MEAS: begin
        if (!Enable) begin
          // Partial period is dropped; lock and error history survive.
          state_d = IDLE;
        end else if (rise) begin
          // Rise takes priority over a timeout in the same cycle.
          high_d   = hi_q;
          period_d = per_q;
          mv_d     = 1'b1;
          per_d    = CNT_ONE;
          hi_d     = CNT_ONE;
          if (good) begin
            if (good_q != LOCK_V) good_d = good_q + 1'b1;
            lock_d = (good_d == LOCK_V);
          end else begin
            ep_d   = 1'b1;
            good_d = '0;
            lock_d = 1'b0;
            if (err_q != '1) err_d = err_q + 1'b1;
          end
        end else if (per_q >= TMO) begin
          state_d = IDLE;
          ep_d    = 1'b1;
          good_d  = '0;
          lock_d  = 1'b0;
          if (err_q != '1) err_d = err_q + 1'b1;
        end else begin
          if (per_q != CNT_MAX) per_d = per_q + 1'b1;
          if (level && (hi_q != CNT_MAX)) hi_d = hi_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      high_q   <= '0;
      period_q <= '0;
      mv_q     <= 1'b0;
      ep_q     <= 1'b0;
      lock_q   <= 1'b0;
      err_q    <= '0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      high_q   <= high_d;
      period_q <= period_d;
      mv_q     <= mv_d;
      ep_q     <= ep_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      good_q   <= good_d;
    end
  end

  assign High_Cnt   = high_q;
  assign Period_Cnt = period_q;
  assign Meas_Valid = mv_q;
  assign Err_Pulse  = ep_q;
  assign Locked     = lock_q;
  assign Err_Cnt    = err_q;

endmodule
